alu_op_sequencer: RTL

//   Sequences ALU operations behind a valid/ready request/response handshake.
//   ADD, SUB and SHIFT complete in one cycle. MUL (shift-add) and DIV (restoring)

---
 rtl/alu_op_sequencer_pkg.sv | 22 ++
 rtl/alu_op_sequencer_if.sv | 26 ++
 rtl/alu_op_sequencer_iter.sv | 100 ++++++++++
 rtl/alu_op_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - opcodes, status bit indices and FSM encoding for the ALU sequencer
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_SHIFT = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;

    localparam int ST_Z   = 0;
    localparam int ST_N   = 1;
    localparam int ST_C   = 2;
    localparam int ST_V   = 3;
    localparam int ST_ERR = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request/response handshake bundle between issue logic and the sequencer
interface alu_op_sequencer_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             status_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic [4:0]       status_out;

    modport master (
        output in_valid, opcode, operand1, operand2, status_in, out_ready,
        input  in_ready, out_valid, result_hi, result_lo, status_out
    );

    modport slave (
        input  in_valid, opcode, operand1, operand2, status_in, out_ready,
        output in_ready, out_valid, result_hi, result_lo, status_out
    );

endinterface

// File: rtl/alu_op_sequencer_iter.sv
// rtl/alu_op_sequencer_iter.sv - alu_iter_unit: shift-add multiply, restoring divide when ALU_SEQ_DIV_EN is defined
module alu_iter_unit #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ALU_SEQ_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opv_q, opv_d;
    logic [WIDTH-1:0] cur_hi, cur_lo, cur_opv;
    logic [WIDTH:0]   sum;
`ifdef ALU_SEQ_DIV_EN
    logic             div_q, div_d, cur_div;
    logic [WIDTH:0]   shifted, trial;
`endif

    assign done   = (cnt_q == CW'(WIDTH));
    assign busy   = (cnt_q != '0) && !done;
    assign res_hi = hi_q;
    assign res_lo = lo_q;

    // One bit per cycle; the start cycle already performs the first step on fresh operands
    always_comb begin
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opv_d   = opv_q;
        cur_hi  = hi_q;
        cur_lo  = lo_q;
        cur_opv = opv_q;
        sum     = '0;
`ifdef ALU_SEQ_DIV_EN
        div_d   = div_q;
        cur_div = div_q;
        shifted = '0;
        trial   = '0;
`endif
        if (start) begin
            cur_hi  = '0;
            cur_lo  = b;
            cur_opv = a;
`ifdef ALU_SEQ_DIV_EN
            cur_div = is_div;
            if (is_div) begin
                cur_lo  = a;
                cur_opv = b;
            end
`endif
        end
        if (start || busy) begin
            cnt_d = start ? CW'(1) : cnt_q + CW'(1);
            opv_d = cur_opv;
            sum   = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_opv} : '0);
            hi_d  = sum[WIDTH:1];
            lo_d  = {sum[0], cur_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
            div_d   = cur_div;
            shifted = {cur_hi, cur_lo[WIDTH-1]};
            trial   = shifted - {1'b0, cur_opv};
            if (cur_div) begin
                hi_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                lo_d = {cur_lo[WIDTH-2:0], ~trial[WIDTH]};
            end
`endif
        end
    end

    // Iteration state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            opv_q <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            opv_q <= opv_d;
`ifdef ALU_SEQ_DIV_EN
            div_q <= div_d;
`endif
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU op sequencer top; DIV enabled by ALU_SEQ_DIV_EN
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  bus
);

    seq_state_t       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [4:0]       st_q, st_d;

    logic             in_ready, go_iter, iter_start, iter_busy, iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo, f_hi, f_lo;
    logic [4:0]       f_st, i_st;
    logic             f_c, f_v, f_err, f_legal;
    logic [WIDTH:0]   sum;
    int               sh;

    assign in_ready       = (state_q == S_IDLE) && !iter_busy;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.result_hi  = hi_q;
    assign bus.result_lo  = lo_q;
    assign bus.status_out = st_q;

`ifdef ALU_SEQ_DIV_EN
    assign go_iter = (bus.opcode == OP_MUL) || ((bus.opcode == OP_DIV) && (bus.operand2 != '0));
`else
    assign go_iter = (bus.opcode == OP_MUL);
`endif

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
`ifdef ALU_SEQ_DIV_EN
        .is_div (bus.opcode == OP_DIV),
`endif
        .a      (bus.operand1),
        .b      (bus.operand2),
        .busy   (iter_busy),
        .done   (iter_done),
        .res_hi (iter_hi),
        .res_lo (iter_lo)
    );

    // Single-cycle results computed straight from the request inputs
    always_comb begin
        f_hi    = '0;
        f_lo    = '0;
        f_c     = 1'b0;
        f_v     = 1'b0;
        f_err   = 1'b0;
        f_legal = 1'b1;
        sum     = '0;
        sh      = 0;
        case (bus.opcode)
            OP_ADD: begin
                sum  = {1'b0, bus.operand1} + {1'b0, bus.operand2} + {{WIDTH{1'b0}}, bus.status_in};
                f_lo = sum[WIDTH-1:0];
                f_c  = sum[WIDTH];
                f_v  = (bus.operand1[WIDTH-1] == bus.operand2[WIDTH-1]) &&
                       (f_lo[WIDTH-1] != bus.operand1[WIDTH-1]);
            end
            OP_SUB: begin
                sum  = {1'b0, bus.operand1} - {1'b0, bus.operand2} - {{WIDTH{1'b0}}, bus.status_in};
                f_lo = sum[WIDTH-1:0];
                f_c  = ~sum[WIDTH];
                f_v  = (bus.operand1[WIDTH-1] != bus.operand2[WIDTH-1]) &&
                       (f_lo[WIDTH-1] != bus.operand1[WIDTH-1]);
            end
            OP_SHIFT: begin
                sh = int'($signed(bus.operand2));
                if (sh == 0) begin
                    f_lo = bus.operand1;
                end else if (sh > 0 && sh < WIDTH) begin
                    f_lo = bus.operand1 >> sh;
                    f_c  = |(bus.operand1 & (WIDTH'(1) << (sh - 1)));
                end else if (sh < 0 && -sh < WIDTH) begin
                    f_lo = bus.operand1 << (-sh);
                    f_c  = |(bus.operand1 & (WIDTH'(1) << (WIDTH + sh)));
                end
            end
            OP_MUL: ;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                if (bus.operand2 == '0) begin
                    f_lo  = '1;
                    f_hi  = bus.operand1;
                    f_err = 1'b1;
                end
            end
`endif
            default: begin
                f_legal = 1'b0;
                f_err   = 1'b1;
            end
        endcase
        f_st = '0;
        if (f_legal) begin
            f_st[ST_Z] = (f_lo == '0);
            f_st[ST_N] = f_lo[WIDTH-1];
            f_st[ST_C] = f_c;
            f_st[ST_V] = f_v;
        end
        f_st[ST_ERR] = f_err;
    end

    // Flags for a finished multiply/divide
    always_comb begin
        i_st       = '0;
        i_st[ST_Z] = (iter_lo == '0);
        i_st[ST_N] = iter_lo[WIDTH-1];
        i_st[ST_C] = (op_q == OP_MUL) && (iter_hi != '0);
        i_st[ST_V] = (op_q == OP_MUL) && (iter_hi != '0);
    end

    // Sequencer FSM: accept, iterate if needed, hold the response until taken
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        st_d       = st_q;
        iter_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready) begin
                    op_d = bus.opcode;
                    if (go_iter) begin
                        iter_start = 1'b1;
                        state_d    = S_ITER;
                    end else begin
                        hi_d    = f_hi;
                        lo_d    = f_lo;
                        st_d    = f_st;
                        state_d = S_DONE;
                    end
                end
            end
            S_ITER: begin
                if (iter_done) begin
                    hi_d    = iter_hi;
                    lo_d    = iter_lo;
                    st_d    = i_st;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            st_q    <= st_d;
        end
    end

endmodule
